// File: rtl/countdown_timer_mmss.sv
// rtl/countdown_timer_mmss.sv - BCD mm:ss countdown timer with alarm
// Optional alarm auto-clear after ALARM_SEC seconds: define TIMER_ALARM_AUTOCLR_EN.
module countdown_timer_mmss #(
  parameter int ALARM_SEC = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_sec,
  input  logic       btn_start,
  input  logic       btn_load,
  input  logic       btn_clear,
  input  logic [3:0] set_sec1,
  input  logic [3:0] set_sec10,
  input  logic [3:0] set_min1,
  input  logic [3:0] set_min10,
  output logic [3:0] sec1,
  output logic [3:0] sec10,
  output logic [3:0] min1,
  output logic [3:0] min10,
  output logic       running,
  output logic       alarm,
  output logic       load_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_ALARM = 2'd3;

  logic [1:0] state_q, state_d;
  logic [3:0] sec1_q, sec1_d, sec10_q, sec10_d;
  logic [3:0] min1_q, min1_d, min10_q, min10_d;
  logic       running_q, running_d;
  logic       alarm_q, alarm_d;
  logic       load_err_q, load_err_d;
  logic       preset_ok, at_one, at_zero;

`ifdef TIMER_ALARM_AUTOCLR_EN
  localparam int ACW = $clog2(ALARM_SEC + 1);
  logic [ACW-1:0] acnt_q, acnt_d;
`else
  logic unused_cfg;
  assign unused_cfg = (ALARM_SEC > 0);
`endif

  assign preset_ok = (set_sec1 <= 4'd9) && (set_sec10 <= 4'd5) &&
                     (set_min1 <= 4'd9) && (set_min10 <= 4'd9);
  assign at_zero   = ({min10_q, min1_q, sec10_q, sec1_q} == 16'h0000);
  assign at_one    = ({min10_q, min1_q, sec10_q, sec1_q} == 16'h0001);

  always_comb begin
    state_d    = state_q;
    sec1_d     = sec1_q;
    sec10_d    = sec10_q;
    min1_d     = min1_q;
    min10_d    = min10_q;
    load_err_d = 1'b0;
`ifdef TIMER_ALARM_AUTOCLR_EN
    acnt_d     = acnt_q;
`endif
    if (btn_clear) begin
      {min10_d, min1_d, sec10_d, sec1_d} = 16'h0000;
      state_d = S_IDLE;
    end else if (btn_load && state_q != S_RUN) begin
      // A rejected preset leaves both value and state untouched.
      if (preset_ok) begin
        {min10_d, min1_d, sec10_d, sec1_d} = {set_min10, set_min1, set_sec10, set_sec1};
        state_d = S_IDLE;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (btn_start) begin
      case (state_q)
        S_IDLE:  if (!at_zero) state_d = S_RUN;
        S_RUN:   state_d = S_PAUSE;
        S_PAUSE: state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end else if (clk_sec) begin
      if (state_q == S_RUN) begin
        if (at_one) begin
          sec1_d  = 4'd0;
          state_d = S_ALARM;
        end else if (sec1_q != 4'd0) begin
          sec1_d = sec1_q - 4'd1;
        end else begin
          sec1_d = 4'd9;
          if (sec10_q != 4'd0) begin
            sec10_d = sec10_q - 4'd1;
          end else begin
            sec10_d = 4'd5;
            if (min1_q != 4'd0) begin
              min1_d = min1_q - 4'd1;
            end else begin
              min1_d  = 4'd9;
              min10_d = min10_q - 4'd1;
            end
          end
        end
      end
`ifdef TIMER_ALARM_AUTOCLR_EN
      else if (state_q == S_ALARM) begin
        if (acnt_q == ACW'(ALARM_SEC - 1)) state_d = S_IDLE;
        else acnt_d = acnt_q + 1'b1;
      end
`endif
    end
`ifdef TIMER_ALARM_AUTOCLR_EN
    if (state_d == S_ALARM && state_q != S_ALARM) acnt_d = '0;
`endif
    running_d = (state_d == S_RUN);
    alarm_d   = (state_d == S_ALARM);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      sec1_q     <= 4'd0;
      sec10_q    <= 4'd0;
      min1_q     <= 4'd0;
      min10_q    <= 4'd0;
      running_q  <= 1'b0;
      alarm_q    <= 1'b0;
      load_err_q <= 1'b0;
`ifdef TIMER_ALARM_AUTOCLR_EN
      acnt_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      sec1_q     <= sec1_d;
      sec10_q    <= sec10_d;
      min1_q     <= min1_d;
      min10_q    <= min10_d;
      running_q  <= running_d;
      alarm_q    <= alarm_d;
      load_err_q <= load_err_d;
`ifdef TIMER_ALARM_AUTOCLR_EN
      acnt_q     <= acnt_d;
`endif
    end
  end

  assign sec1     = sec1_q;
  assign sec10    = sec10_q;
  assign min1     = min1_q;
  assign min10    = min10_q;
  assign running  = running_q;
  assign alarm    = alarm_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer_mmss.sv
// tb/tb_countdown_timer_mmss.sv - randomized bench for countdown_timer_mmss against a seconds-count model
module tb_countdown_timer_mmss;

  localparam int M_ALARM_SEC = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clk_sec = 1'b0, btn_start = 1'b0, btn_load = 1'b0, btn_clear = 1'b0;
  logic [3:0] set_sec1 = 4'd0, set_sec10 = 4'd0, set_min1 = 4'd0, set_min10 = 4'd0;
  logic [3:0] sec1, sec10, min1, min10;
  logic       running, alarm, load_err;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: value held as plain seconds, state as a small integer.
  int m_val = 0;
  int m_st  = M_IDLE;
  int m_acnt = 0;
  bit m_err = 0;

  countdown_timer_mmss #(.ALARM_SEC(M_ALARM_SEC)) dut (
    .clk(clk), .reset_n(reset_n), .clk_sec(clk_sec),
    .btn_start(btn_start), .btn_load(btn_load), .btn_clear(btn_clear),
    .set_sec1(set_sec1), .set_sec10(set_sec10), .set_min1(set_min1), .set_min10(set_min10),
    .sec1(sec1), .sec10(sec10), .min1(min1), .min10(min10),
    .running(running), .alarm(alarm), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    int m, s;
    m = v / 60;
    s = v % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_step(input bit clr, input bit ld, input bit st, input bit sec, input logic [15:0] p);
    bit ok;
    ok = (p[15:12] <= 9) && (p[11:8] <= 9) && (p[7:4] <= 5) && (p[3:0] <= 9);
    m_err = 0;
    if (clr) begin
      m_val = 0;
      m_st  = M_IDLE;
    end else if (ld && m_st != M_RUN) begin
      if (ok) begin
        m_val = (int'(p[15:12]) * 10 + int'(p[11:8])) * 60 + int'(p[7:4]) * 10 + int'(p[3:0]);
        m_st  = M_IDLE;
      end else begin
        m_err = 1;
      end
    end else if (st) begin
      if (m_st == M_IDLE) begin
        if (m_val != 0) m_st = M_RUN;
      end else if (m_st == M_RUN) m_st = M_PAUSE;
      else if (m_st == M_PAUSE) m_st = M_RUN;
      else m_st = M_IDLE;
    end else if (sec) begin
      if (m_st == M_RUN) begin
        m_val = m_val - 1;
        if (m_val == 0) begin
          m_st = M_ALARM;
          m_acnt = 0;
        end
      end
`ifdef TIMER_ALARM_AUTOCLR_EN
      else if (m_st == M_ALARM) begin
        m_acnt++;
        if (m_acnt == M_ALARM_SEC) m_st = M_IDLE;
      end
`endif
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".digits"}, {16'h0, min10, min1, sec10, sec1}, {16'h0, to_bcd(m_val)});
    check({tag, ".running"}, {31'h0, running}, {31'h0, m_st == M_RUN});
    check({tag, ".alarm"}, {31'h0, alarm}, {31'h0, m_st == M_ALARM});
    check({tag, ".load_err"}, {31'h0, load_err}, {31'h0, m_err});
  endtask

  task automatic tick(input string tag, input bit clr, input bit ld, input bit st, input bit sec,
                      input logic [15:0] p);
    @(negedge clk);
    btn_clear = clr; btn_load = ld; btn_start = st; clk_sec = sec;
    {set_min10, set_min1, set_sec10, set_sec1} = p;
    @(posedge clk);
    model_step(clr, ld, st, sec, p);
    #1;
    btn_clear = 0; btn_load = 0; btn_start = 0; clk_sec = 0;
    {set_min10, set_min1, set_sec10, set_sec1} = $urandom();
    compare_all(tag);
  endtask

  initial begin
    logic [15:0] p;
    bit clr, ld, st, sec;
    repeat (2) @(posedge clk);
    #1;
    compare_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    tick("idle_start", 0, 0, 1, 0, 16'h0);
    tick("idle_start2", 0, 0, 0, 1, 16'h0);

    tick("load_0102", 0, 1, 0, 0, 16'h0102);
    tick("start", 0, 0, 1, 0, 16'h0);
    for (int i = 0; i < 62; i++) begin
      tick("countdown", 0, 0, 0, 1, 16'h0);
      if ($urandom_range(0, 1) == 1) tick("gap", 0, 0, 0, 0, 16'h0);
    end
    repeat (3) tick("after_zero", 0, 0, 0, 1, 16'h0);
    tick("clr_alarm", 1, 0, 0, 0, 16'h0);

    tick("load_0347", 0, 1, 0, 0, 16'h0347);
    tick("bad_sec10", 0, 1, 0, 0, 16'h0060);
    tick("err_drop", 0, 0, 0, 0, 16'h0);
    tick("bad_min1", 0, 1, 0, 0, 16'h0A00);
    tick("err_drop2", 0, 0, 0, 0, 16'h0);

    tick("load_0500", 0, 1, 0, 0, 16'h0500);
    tick("run_0500", 0, 0, 1, 0, 16'h0);
    tick("start_sec", 0, 0, 1, 1, 16'h0);
    tick("pause_hold", 0, 0, 0, 1, 16'h0);
    tick("clr_ld", 1, 1, 0, 0, 16'h0230);

    tick("load_1234", 0, 1, 0, 0, 16'h1234);
    tick("run_1234", 0, 0, 1, 0, 16'h0);
    tick("run_idle", 0, 0, 0, 0, 16'h0);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    m_val = 0; m_st = M_IDLE; m_err = 0;
    compare_all("async_rst");
    @(negedge clk);
    reset_n = 1'b1;

    tick("load_0001", 0, 1, 0, 0, 16'h0001);
    tick("start_0001", 0, 0, 1, 0, 16'h0);
    tick("to_alarm", 0, 0, 0, 1, 16'h0);
    for (int i = 0; i < 20; i++) tick("alarm_ticks", 0, 0, 0, 1, 16'h0);
    tick("alarm_clr", 1, 0, 0, 0, 16'h0);

    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 39) == 0);
      ld  = ($urandom_range(0, 14) == 0);
      st  = ($urandom_range(0, 9) == 0);
      sec = ($urandom_range(0, 2) == 0);
      p[3:0]   = 4'($urandom_range(0, 9));
      p[7:4]   = 4'($urandom_range(0, 5));
      p[11:8]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 9)) : 4'd0;
      p[15:12] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 9)) : 4'd0;
      if ($urandom_range(0, 7) == 0) p[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(0, 15));
      tick("rand", clr, ld, st, sec, p);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
